// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART transmit arbiter
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int DEF_START_TIMEOUT = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT_START = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, one-hot grant plus index
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] k;
  always_comb begin
    idx = '0;
    k = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N_REQ);
      idx = req[k] ? k : idx;
    end
    gnt = |req ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte scheduler with packet lock feeding one UART transmitter
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [BYTE_W*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]        i_req_last,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_send_en,
  output logic [BYTE_W-1:0]       o_tx_data,
  input  logic                    i_tx_done,
  output logic                    o_busy,
  output logic [2:0]              o_grant_id,
  output logic                    o_timeout_err
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic lock_en, last_q, accept;
  logic [IW-1:0] lock_id, rr_ptr, grant_id, win, next_ptr;
  logic [N_REQ-1:0] cand, gnt;
  logic [BYTE_W-1:0] lane_data;
  assign cand = lock_en ? i_req_valid & (N_REQ'(1) << lock_id) : i_req_valid;
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (.req(cand), .ptr(rr_ptr), .gnt(gnt), .idx(win));
  always_comb begin
    lane_data = '0;
    for (int r = 0; r < N_REQ; r++)
      lane_data = win == IW'(r) ? i_req_data[BYTE_W*r +: BYTE_W] : lane_data;
  end
  assign accept = state == ST_IDLE && i_tx_done && |cand;
  assign o_req_ready = accept ? gnt : '0;
  assign o_send_en = state == ST_SEND;
  assign o_busy = state != ST_IDLE || lock_en;
  assign o_grant_id = 3'(grant_id);
  assign o_timeout_err = state == ST_WAIT_START && i_tx_done && cnt >= CW'(START_TIMEOUT - 1);
  assign next_ptr = grant_id == IW'(N_REQ - 1) ? '0 : grant_id + 1'b1;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      lock_en <= 1'b0;
      lock_id <= '0;
      rr_ptr <= '0;
      grant_id <= '0;
      last_q <= 1'b0;
      o_tx_data <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          o_tx_data <= lane_data;
          last_q <= i_req_last[win];
          grant_id <= win;
          lock_en <= !i_req_last[win];
          lock_id <= win;
          state <= ST_SEND;
        end
        ST_SEND: begin
          cnt <= '0;
          state <= ST_WAIT_START;
        end
        ST_WAIT_START: if (!i_tx_done) state <= ST_WAIT_DONE;
        else if (o_timeout_err) begin
          lock_en <= 1'b0;
          rr_ptr <= next_ptr;
          state <= ST_IDLE;
        end else cnt <= cnt == CW'(START_TIMEOUT) ? cnt : cnt + 1'b1;
        default: if (i_tx_done) begin
          rr_ptr <= last_q ? next_ptr : rr_ptr;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
